// File: rtl/rob_pkg.sv
// Shared definitions for the ROB internal-tag allocator.
// Holds the default matrix geometry, the index-width helpers and the
// tag / per-row state record types used by the allocator and its row FIFOs.
package rob_pkg;

  localparam int NUM_ROWS_DEF = 4;
  localparam int NUM_COLS_DEF = 4;

  // Index widths; a dimension of 1 still gets a 1-bit index so ports never
  // collapse to zero width.
  function automatic int row_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int col_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ROW_W_DEF = row_w(NUM_ROWS_DEF);
  localparam int COL_W_DEF = col_w(NUM_COLS_DEF);

  // Internal RID as seen by the tag map: {row, col}.
  typedef struct packed {
    logic [ROW_W_DEF-1:0] row;
    logic [COL_W_DEF-1:0] col;
  } rob_tag_t;

  // Bookkeeping of one row at the default geometry.
  typedef struct packed {
    logic [COL_W_DEF-1:0] head;
    logic [COL_W_DEF-1:0] tail;
    logic [COL_W_DEF:0]   count;
  } rob_row_state_t;

endpackage

// File: rtl/rob_row_fifo_ctrl.sv
// Bookkeeping for one row of the tag matrix.
// Columns are handed out at tail and retired at head in strict FIFO order.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   inc        allocate the column at tail on this edge
//   dec        retire the column at head on this edge
//   full       count == NUM_COLS
//   empty      count == 0
//   head       oldest outstanding column (next legal retire)
//   tail       next column to hand out
//   used       per-column allocated bits
module rob_row_fifo_ctrl
  import rob_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  localparam int COL_W = col_w(NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  output logic                full,
  output logic                empty,
  output logic [COL_W-1:0]    head,
  output logic [COL_W-1:0]    tail,
  output logic [NUM_COLS-1:0] used
);

  logic [COL_W:0] count;

  // Pointers wrap through natural COL_W overflow. inc and dec never target
  // the same column in one cycle, so the two used-bit writes never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      used  <= '0;
    end else begin
      if (inc) begin
        used[tail] <= 1'b1;
        tail       <= tail + COL_W'(1);
      end
      if (dec) begin
        used[head] <= 1'b0;
        head       <= head + COL_W'(1);
      end
      case ({inc, dec})
        2'b10:   count <= count + (COL_W+1)'(1);
        2'b01:   count <= count - (COL_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (COL_W+1)'(NUM_COLS));
  assign empty = (count == '0);

endmodule

// File: rtl/rob_id_alloc_ctrl.sv
// Global internal-tag allocator and retire sequencer for the read reorder path.
// Tags form a NUM_ROWS x NUM_COLS matrix; an internal RID is {row,col}.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alloc_req/alloc_row            AR path asks for a column in a row
//   alloc_gnt/alloc_col            combinational grant and granted column
//   free_req/free_row/free_col     R path retires a tag on last beat
//   free_gnt/free_misorder         combinational accept / reject pulse
//   err_sticky                     latched on any rejected retire
//   row_full/row_empty             per-row occupancy status
//   used_slots                     allocated bitmap, bit row*NUM_COLS+col
//   all_idle                       every row empty
module rob_id_alloc_ctrl
  import rob_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int NUM_COLS = NUM_COLS_DEF,
  localparam int ROW_W = row_w(NUM_ROWS),
  localparam int COL_W = col_w(NUM_COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_req,
  input  logic [ROW_W-1:0]             alloc_row,
  output logic                         alloc_gnt,
  output logic [COL_W-1:0]             alloc_col,
  input  logic                         free_req,
  input  logic [ROW_W-1:0]             free_row,
  input  logic [COL_W-1:0]             free_col,
  output logic                         free_gnt,
  output logic                         free_misorder,
  output logic                         err_sticky,
  output logic [NUM_ROWS-1:0]          row_full,
  output logic [NUM_ROWS-1:0]          row_empty,
  output logic [NUM_ROWS*NUM_COLS-1:0] used_slots,
  output logic                         all_idle
);

  logic [COL_W-1:0]    head_a [NUM_ROWS];
  logic [COL_W-1:0]    tail_a [NUM_ROWS];
  logic [NUM_COLS-1:0] used_a [NUM_ROWS];
  logic [NUM_ROWS-1:0] inc;
  logic [NUM_ROWS-1:0] dec;
  logic                free_legal;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    rob_row_fifo_ctrl #(.NUM_COLS(NUM_COLS)) u_row (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[r]),
      .dec   (dec[r]),
      .full  (row_full[r]),
      .empty (row_empty[r]),
      .head  (head_a[r]),
      .tail  (tail_a[r]),
      .used  (used_a[r])
    );
    assign used_slots[r*NUM_COLS +: NUM_COLS] = used_a[r];
  end

  // Fullness comes from registered state only, so a same-cycle retire on a
  // full row does not open the slot until the next cycle. The alloc and free
  // decisions use disjoint inputs, keeping the two paths independent.
  assign alloc_gnt  = alloc_req && !rst && !row_full[alloc_row];
  assign alloc_col  = tail_a[alloc_row];

  assign free_legal    = used_a[free_row][free_col] && (free_col == head_a[free_row]);
  assign free_gnt      = free_req && !rst && free_legal;
  assign free_misorder = free_req && !rst && !free_legal;

  assign all_idle = &row_empty;

  // One-hot row strobes for the row FIFOs.
  always_comb begin
    inc = '0;
    dec = '0;
    inc[alloc_row] = alloc_gnt;
    dec[free_row]  = free_gnt;
  end

  // Any rejected retire is remembered until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (free_misorder) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_id_alloc_ctrl.sv
// Self-checking bench for rob_id_alloc_ctrl: directed scenarios followed by
// random traffic, compared against a queue-per-row reference model.
module tb_rob_id_alloc_ctrl;

  localparam int NR = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic [1:0]    alloc_row;
  logic          alloc_gnt;
  logic [1:0]    alloc_col;
  logic          free_req;
  logic [1:0]    free_row;
  logic [1:0]    free_col;
  logic          free_gnt;
  logic          free_misorder;
  logic          err_sticky;
  logic [NR-1:0] row_full;
  logic [NR-1:0] row_empty;
  logic [15:0]   used_slots;
  logic          all_idle;

  int total = 0;
  int bad   = 0;

  // Reference model: each row is a queue of outstanding columns in issue
  // order; next_col is the column the next allocation receives.
  int q [NR][$];
  int next_col [NR];
  bit m_err;

  always #5 clk = ~clk;

  rob_id_alloc_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_row     (alloc_row),
    .alloc_gnt     (alloc_gnt),
    .alloc_col     (alloc_col),
    .free_req      (free_req),
    .free_row      (free_row),
    .free_col      (free_col),
    .free_gnt      (free_gnt),
    .free_misorder (free_misorder),
    .err_sticky    (err_sticky),
    .row_full      (row_full),
    .row_empty     (row_empty),
    .used_slots    (used_slots),
    .all_idle      (all_idle)
  );

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      q[r].delete();
      next_col[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_status();
    logic [15:0]   e_used;
    logic [NR-1:0] e_full;
    logic [NR-1:0] e_empty;
    e_used = '0;
    for (int r = 0; r < NR; r++) begin
      e_full[r]  = (q[r].size() == NC);
      e_empty[r] = (q[r].size() == 0);
      for (int i = 0; i < q[r].size(); i++) e_used[r*NC + q[r][i]] = 1'b1;
    end
    check_output("used_slots", 32'(used_slots), 32'(e_used));
    check_output("row_full",   32'(row_full),   32'(e_full));
    check_output("row_empty",  32'(row_empty),  32'(e_empty));
    check_output("all_idle",   32'(all_idle),   32'(&e_empty));
    check_output("err_sticky", 32'(err_sticky), 32'(m_err));
  endtask

  // One clock cycle: drive inputs just after an edge, check the
  // combinational grants, then check registered status after the edge.
  task automatic apply_stimulus(bit ar, int arow_i, bit fr, int frow_i, int fcol_i, bit do_rst);
    bit e_ag, e_fg, e_mis, legal;
    rst       = do_rst;
    alloc_req = ar;
    alloc_row = 2'(arow_i);
    free_req  = fr;
    free_row  = 2'(frow_i);
    free_col  = 2'(fcol_i);
    #1;
    legal = (q[frow_i].size() > 0) && (q[frow_i][0] == fcol_i);
    e_ag  = !do_rst && ar && (q[arow_i].size() < NC);
    e_fg  = !do_rst && fr && legal;
    e_mis = !do_rst && fr && !legal;
    check_output("alloc_gnt", 32'(alloc_gnt), 32'(e_ag));
    if (e_ag) check_output("alloc_col", 32'(alloc_col), 32'(next_col[arow_i]));
    check_output("free_gnt", 32'(free_gnt), 32'(e_fg));
    check_output("free_misorder", 32'(free_misorder), 32'(e_mis));
    @(posedge clk);
    if (do_rst) begin
      model_reset();
    end else begin
      if (e_mis) m_err = 1'b1;
      if (e_fg) void'(q[frow_i].pop_front());
      if (e_ag) begin
        q[arow_i].push_back(next_col[arow_i]);
        next_col[arow_i] = (next_col[arow_i] + 1) % NC;
      end
    end
    #1;
    check_status();
    rst       = 1'b0;
    alloc_req = 1'b0;
    free_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; alloc_row = '0;
    free_req = 1'b0; free_row = '0; free_col = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset and idle inputs
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);

    // Fill row 2, refuse the fifth, row 1 still allocates
    for (int i = 0; i < 4; i++) apply_stimulus(1, 2, 0, 0, 0, 0);
    check_output("row2_full", 32'(row_full[2]), 32'd1);
    apply_stimulus(1, 2, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);

    // Retire {2,0}, then wrapped allocation of col 0
    apply_stimulus(0, 0, 1, 2, 0, 0);
    apply_stimulus(1, 2, 0, 0, 0, 0);
    check_output("row2_full_again", 32'(row_full[2]), 32'd1);

    // Out-of-order retire in row 0, then in-order retire
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1, 0);
    check_output("err_after_misorder", 32'(err_sticky), 32'd1);
    apply_stimulus(0, 0, 1, 0, 0, 0);

    // Retire on empty row 3
    apply_stimulus(0, 0, 1, 3, 0, 0);
    check_output("row3_empty", 32'(row_empty[3]), 32'd1);

    // Row 1 to count 2, then simultaneous alloc and free in row 1
    apply_stimulus(1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 1, q[1][0], 0);

    // Fill row 0, then same-cycle alloc and legal free on the full row
    while (q[0].size() < NC) apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, q[0][0], 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);

    // Reset mid-stream with requests active
    apply_stimulus(1, 3, 1, 2, q[2][0], 1);
    check_output("rst_used", 32'(used_slots), 32'd0);
    check_output("rst_idle", 32'(all_idle), 32'd1);
    check_output("rst_err",  32'(err_sticky), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int ar_r, fr_r, fc;
      bit ar, fr, rs;
      ar   = ($urandom_range(0, 99) < 60);
      fr   = ($urandom_range(0, 99) < 55);
      rs   = ($urandom_range(0, 99) < 2);
      ar_r = $urandom_range(0, NR-1);
      fr_r = $urandom_range(0, NR-1);
      if (q[fr_r].size() > 0 && $urandom_range(0, 99) < 75) fc = q[fr_r][0];
      else fc = $urandom_range(0, NC-1);
      apply_stimulus(ar, ar_r, fr, fr_r, fc, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
